// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with registered one-hot grant, hold timeout and a one-cycle bubble between grants
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 expired
);
  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold;
  logic [IW-1:0] w_win;
  logic          w_found;
  logic          w_release;
  // first set request at or after r_ptr, wrapping modulo N
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N; i++)
      if (!w_found && req[(int'(r_ptr) + i) % N]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_ptr) + i) % N);
      end
  end
  assign w_release = !req[gnt_idx] || (MAX_HOLD != 0 && r_hold == HW'(MAX_HOLD));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_hold    <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (r_state == IDLE) begin
        if (w_found) begin
          gnt       <= N'(1) << w_win;
          gnt_idx   <= w_win;
          gnt_valid <= 1'b1;
          r_hold    <= HW'(1);
          r_state   <= BUSY;
        end
      end else if (w_release) begin
        gnt       <= '0;
        gnt_valid <= 1'b0;
        r_ptr     <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        r_hold    <= '0;
        r_state   <= IDLE;
        expired   <= req[gnt_idx];
      end else if (MAX_HOLD != 0) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed plan plus randomized traffic against a behavioural arbiter model
module tb_rr_grant_arbiter;
  localparam int N    = 4;
  localparam int MAXH = 8;
  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic         expired;
  int n_chk  = 0;
  int n_fail = 0;
  bit m_busy = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_exp = 0;
  int run = 0;

  rr_grant_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_exp = 0; run = 0;
  endtask

  // one clock edge of the arbiter rules, applied to the sampled request vector
  task automatic model_edge(input logic [N-1:0] r);
    m_exp = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++)
        if (r[(m_ptr + k) % N]) begin
          m_busy = 1; m_owner = (m_ptr + k) % N; m_hold = 1;
          break;
        end
    end else if (!r[m_owner] || m_hold == MAXH) begin
      m_exp  = r[m_owner];
      m_busy = 0; m_ptr = (m_owner + 1) % N; m_hold = 0;
    end else m_hold++;
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    eg = m_busy ? N'(1) << m_owner : '0;
    run = gnt_valid ? run + 1 : 0;
    chk("gnt", gnt, eg);
    chk("gnt_valid", gnt_valid, m_busy);
    chk("gnt_idx", gnt_idx, m_owner);
    chk("expired", expired, m_exp);
    chk("onehot", $countones(gnt) <= 1, 1);
    chk("valid_or", gnt_valid, |gnt);
    chk("exp_vs_valid", expired && gnt_valid, 0);
    chk("max_run", run <= MAXH, 1);
  endtask

  // called at a falling edge: drive req, cross one rising edge, check at the next falling edge
  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    compare();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    chk("rst_gnt", gnt, 0);
    rst_n = 1'b1;
    // single requester
    step(4'b0100);
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_idx", gnt_idx, 2);
    step(4'b0100);
    step(4'b0100);
    chk("t1_held", gnt, 4'b0100);
    step(4'b0000);
    chk("t1_rel", gnt, 0);
    // wrap-around from ptr=3
    step(4'b0011);
    chk("t3_wrap", gnt, 4'b0001);
    step(4'b0010);
    chk("t3_bubble", gnt, 0);
    step(4'b0010);
    chk("t3_next", gnt, 4'b0010);
    step(4'b0000);
    // rotation from ptr=0 after a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(4'b1111);
      chk("t2_order", gnt_idx, k % N);
      step(4'b1111);
      step(4'b1111 & ~(4'b0001 << (k % N)));
      chk("t2_bubble", gnt, 0);
    end
    // timeout on a sole persistent requester
    for (int k = 0; k < MAXH; k++) begin
      step(4'b0010);
      chk("t4_hold", gnt, 4'b0010);
    end
    step(4'b0010);
    chk("t4_gnt0", gnt, 0);
    chk("t4_exp", expired, 1);
    step(4'b0010);
    chk("t4_regnt", gnt, 4'b0010);
    chk("t4_exp_clr", expired, 0);
    // release in the same cycle the hold limit is reached
    for (int k = 1; k < MAXH; k++) step(4'b0010);
    step(4'b0000);
    chk("t5_gnt0", gnt, 0);
    chk("t5_noexp", expired, 0);
    // asynchronous reset mid-grant
    step(4'b1000);
    chk("t6_pre", gnt, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_gnt", gnt, 0);
    chk("t6_valid", gnt_valid, 0);
    chk("t6_exp", expired, 0);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001);
    chk("t6_first", gnt, 4'b0001);
    step(4'b0000);
    // randomized traffic with sticky request patterns so timeouts occur
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 7) == 0) ? N'($urandom) : req);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
